// File: rtl/fetch_unit.sv
// fetch_unit: parametrised instruction-fetch stage.
// Owns the program counter, reads instruction memory asynchronously at
// imem_addr, and presents a registered IF/ID bundle with a valid bit.
// Two-word instructions (opcode word with bit IMM_BIT set, followed by an
// immediate word) are assembled over two cycles with one bubble.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   stall        hold PC, state and all outputs
//   branch       redirect fetch to sign-extended branch_addr (overrides stall)
//   branch_addr  branch target, BR_W bits
//   imem_addr    instruction-memory address (= PC)
//   imem_data    instruction-memory read data for imem_addr
//   if_valid     IF/ID holds a valid instruction
//   if_inst      opcode word
//   if_imm       immediate word (0 for single-word instructions)
//   if_has_imm   instruction is two-word
//   if_pc        address of the opcode word
//   if_pc_next   address following the whole instruction
module fetch_unit #(
    parameter int unsigned PC_W     = 32,
    parameter int unsigned INST_W   = 16,
    parameter int unsigned BR_W     = 16,
    parameter int unsigned RESET_PC = 50,
    parameter int unsigned IMM_BIT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch,
    input  logic [BR_W-1:0]   branch_addr,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_data,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    output logic [INST_W-1:0] if_imm,
    output logic              if_has_imm,
    output logic [PC_W-1:0]   if_pc,
    output logic [PC_W-1:0]   if_pc_next
);

    typedef enum logic {
        FETCH,
        FETCH_IMM
    } state_t;

    state_t            state, state_nx;
    logic [PC_W-1:0]   pc, pc_nx, pc_inc, br_target;
    logic [PC_W-1:0]   hold_pc, hold_pc_nx;
    logic [INST_W-1:0] hold_inst, hold_inst_nx;

    logic              valid_nx, has_imm_nx;
    logic [INST_W-1:0] inst_nx, imm_nx;
    logic [PC_W-1:0]   ifpc_nx, ifpc_next_nx;

    assign imem_addr = pc;
    assign pc_inc    = pc + PC_W'(1);
    // Size cast of a signed operand replicates the sign bit upward.
    assign br_target = PC_W'($signed(branch_addr));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= PC_W'(RESET_PC);
            hold_pc    <= '0;
            hold_inst  <= '0;
            if_valid   <= 1'b0;
            if_inst    <= '0;
            if_imm     <= '0;
            if_has_imm <= 1'b0;
            if_pc      <= '0;
            if_pc_next <= '0;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            hold_pc    <= hold_pc_nx;
            hold_inst  <= hold_inst_nx;
            if_valid   <= valid_nx;
            if_inst    <= inst_nx;
            if_imm     <= imm_nx;
            if_has_imm <= has_imm_nx;
            if_pc      <= ifpc_nx;
            if_pc_next <= ifpc_next_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        pc_nx        = pc;
        hold_pc_nx   = hold_pc;
        hold_inst_nx = hold_inst;
        valid_nx     = if_valid;
        inst_nx      = if_inst;
        imm_nx       = if_imm;
        has_imm_nx   = if_has_imm;
        ifpc_nx      = if_pc;
        ifpc_next_nx = if_pc_next;

        if (branch) begin
            // Returning to FETCH abandons any half-assembled two-word instruction.
            pc_nx    = br_target;
            state_nx = FETCH;
            valid_nx = 1'b0;
        end else if (!stall) begin
            pc_nx = pc_inc;
            case (state)
                FETCH: begin
                    if (imem_data[IMM_BIT]) begin
                        hold_inst_nx = imem_data;
                        hold_pc_nx   = pc;
                        valid_nx     = 1'b0;
                        state_nx     = FETCH_IMM;
                    end else begin
                        inst_nx      = imem_data;
                        imm_nx       = '0;
                        has_imm_nx   = 1'b0;
                        ifpc_nx      = pc;
                        ifpc_next_nx = pc_inc;
                        valid_nx     = 1'b1;
                    end
                end
                FETCH_IMM: begin
                    // The second word is always the immediate, whatever its IMM_BIT.
                    inst_nx      = hold_inst;
                    imm_nx       = imem_data;
                    has_imm_nx   = 1'b1;
                    ifpc_nx      = hold_pc;
                    ifpc_next_nx = pc_inc;
                    valid_nx     = 1'b1;
                    state_nx     = FETCH;
                end
                default: state_nx = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// Instance A uses default parameters; instance B is an 8-bit PC/branch
// instance for wrap-around. Directed scenarios compare against constants;
// the random scenario compares against an instruction-level model.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // ---------------- instance A (PC_W=32) ----------------
    logic        reset_a, stall_a, branch_a;
    logic [15:0] ba_a;
    logic [31:0] addr_a;
    logic [15:0] data_a;
    logic        valid_a, has_a;
    logic [15:0] inst_a, imm_a;
    logic [31:0] pc_a, pcn_a;
    logic [15:0] mem_a [256];

    assign data_a = mem_a[addr_a[7:0]];

    fetch_unit #(
        .PC_W(32), .INST_W(16), .BR_W(16), .RESET_PC(50), .IMM_BIT(15)
    ) dut_a (
        .clk(clk), .reset(reset_a), .stall(stall_a), .branch(branch_a),
        .branch_addr(ba_a), .imem_addr(addr_a), .imem_data(data_a),
        .if_valid(valid_a), .if_inst(inst_a), .if_imm(imm_a),
        .if_has_imm(has_a), .if_pc(pc_a), .if_pc_next(pcn_a)
    );

    // ---------------- instance B (PC_W=8) ----------------
    logic        reset_b, stall_b, branch_b;
    logic [7:0]  ba_b;
    logic [7:0]  addr_b;
    logic [15:0] data_b;
    logic        valid_b, has_b;
    logic [15:0] inst_b, imm_b;
    logic [7:0]  pc_b, pcn_b;
    logic [15:0] mem_b [256];

    assign data_b = mem_b[addr_b];

    fetch_unit #(
        .PC_W(8), .INST_W(16), .BR_W(8), .RESET_PC(50), .IMM_BIT(15)
    ) dut_b (
        .clk(clk), .reset(reset_b), .stall(stall_b), .branch(branch_b),
        .branch_addr(ba_b), .imem_addr(addr_b), .imem_data(data_b),
        .if_valid(valid_b), .if_inst(inst_b), .if_imm(imm_b),
        .if_has_imm(has_b), .if_pc(pc_b), .if_pc_next(pcn_b)
    );

    typedef struct packed {
        logic        valid;
        logic [15:0] inst;
        logic [15:0] imm;
        logic        has;
        logic [31:0] pc;
        logic [31:0] pcn;
        logic [31:0] addr;
    } snap_t;

    function automatic snap_t snap_a();
        snap_t s;
        s.valid = valid_a; s.inst = inst_a; s.imm = imm_a; s.has = has_a;
        s.pc = pc_a; s.pcn = pcn_a; s.addr = addr_a;
        return s;
    endfunction

    function automatic snap_t mk(input logic v, input logic [15:0] i, input logic [15:0] im,
                                 input logic h, input logic [31:0] p, input logic [31:0] pn,
                                 input logic [31:0] a);
        snap_t s;
        s.valid = v; s.inst = i; s.imm = im; s.has = h; s.pc = p; s.pcn = pn; s.addr = a;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        snap_t e;
        mem_a[50] = 16'h1234; mem_a[51] = 16'h8001; mem_a[52] = 16'h00AA; mem_a[53] = 16'h0005;
        reset_a = 1'b1; stall_a = 1'b0; branch_a = 1'b0; ba_a = '0;
        tick();
        e = mk(0, 16'h0, 16'h0, 0, 32'd0, 32'd0, 32'd50);
        checks++;
        if (snap_a() !== e) begin fails++; $display("FAIL reset: got %h required %h", snap_a(), e); end
        tick();
        checks++;
        if (snap_a() !== e) begin fails++; $display("FAIL reset_hold: got %h required %h", snap_a(), e); end
        reset_a = 1'b0;
    endtask

    task automatic test_single_word();
        snap_t e;
        tick();
        e = mk(1, 16'h1234, 16'h0, 0, 32'd50, 32'd51, 32'd51);
        checks++;
        if (snap_a() !== e) begin fails++; $display("FAIL single_word: got %h required %h", snap_a(), e); end
    endtask

    task automatic test_two_word();
        snap_t e;
        tick();
        e = mk(0, 16'h1234, 16'h0, 0, 32'd50, 32'd51, 32'd52);
        checks++;
        if (snap_a() !== e) begin fails++; $display("FAIL two_word_bubble: got %h required %h", snap_a(), e); end
        tick();
        e = mk(1, 16'h8001, 16'h00AA, 1, 32'd51, 32'd53, 32'd53);
        checks++;
        if (snap_a() !== e) begin fails++; $display("FAIL two_word: got %h required %h", snap_a(), e); end
    endtask

    task automatic test_stall();
        snap_t e;
        e = mk(1, 16'h8001, 16'h00AA, 1, 32'd51, 32'd53, 32'd53);
        stall_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (snap_a() !== e) begin fails++; $display("FAIL stall[%0d]: got %h required %h", i, snap_a(), e); end
        end
        branch_a = 1'b1; ba_a = 16'h0010;
        tick();
        e = mk(0, 16'h8001, 16'h00AA, 1, 32'd51, 32'd53, 32'h10);
        checks++;
        if (snap_a() !== e) begin fails++; $display("FAIL stall_branch: got %h required %h", snap_a(), e); end
        stall_a = 1'b0;
    endtask

    task automatic test_branch_sext();
        snap_t e;
        mem_a[8'hF0] = 16'h0042; mem_a[8'hF1] = 16'h8123; mem_a[8'hF2] = 16'h5555;
        branch_a = 1'b1; ba_a = 16'hFFF0;
        tick();
        e = mk(0, 16'h8001, 16'h00AA, 1, 32'd51, 32'd53, 32'hFFFFFFF0);
        checks++;
        if (snap_a() !== e) begin fails++; $display("FAIL branch_sext: got %h required %h", snap_a(), e); end
        branch_a = 1'b0;
        tick();
        e = mk(1, 16'h0042, 16'h0, 0, 32'hFFFFFFF0, 32'hFFFFFFF1, 32'hFFFFFFF1);
        checks++;
        if (snap_a() !== e) begin fails++; $display("FAIL branch_target: got %h required %h", snap_a(), e); end
        // Two-word instruction stalled mid-way must still complete.
        tick();
        e = mk(0, 16'h0042, 16'h0, 0, 32'hFFFFFFF0, 32'hFFFFFFF1, 32'hFFFFFFF2);
        stall_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (snap_a() !== e) begin fails++; $display("FAIL stall_imm[%0d]: got %h required %h", i, snap_a(), e); end
            if (i < 2) tick();
        end
        stall_a = 1'b0;
        tick();
        e = mk(1, 16'h8123, 16'h5555, 1, 32'hFFFFFFF1, 32'hFFFFFFF3, 32'hFFFFFFF3);
        checks++;
        if (snap_a() !== e) begin fails++; $display("FAIL stall_imm_done: got %h required %h", snap_a(), e); end
    endtask

    task automatic test_abort();
        snap_t e;
        mem_a[8'h60] = 16'h8AAA; mem_a[8'h61] = 16'h0777; mem_a[8'h70] = 16'h0070;
        branch_a = 1'b1; ba_a = 16'h0060;
        tick();
        branch_a = 1'b0;
        tick();
        e = mk(0, 16'h8123, 16'h5555, 1, 32'hFFFFFFF1, 32'hFFFFFFF3, 32'h61);
        checks++;
        if (snap_a() !== e) begin fails++; $display("FAIL abort_setup: got %h required %h", snap_a(), e); end
        branch_a = 1'b1; ba_a = 16'h0070;
        tick();
        e = mk(0, 16'h8123, 16'h5555, 1, 32'hFFFFFFF1, 32'hFFFFFFF3, 32'h70);
        checks++;
        if (snap_a() !== e) begin fails++; $display("FAIL abort_branch: got %h required %h", snap_a(), e); end
        branch_a = 1'b0;
        tick();
        e = mk(1, 16'h0070, 16'h0, 0, 32'h70, 32'h71, 32'h71);
        checks++;
        if (snap_a() !== e) begin fails++; $display("FAIL abort_branch_next: got %h required %h", snap_a(), e); end
        branch_a = 1'b1; ba_a = 16'h0060;
        tick();
        branch_a = 1'b0;
        tick();
        reset_a = 1'b1;
        tick();
        e = mk(0, 16'h0, 16'h0, 0, 32'd0, 32'd0, 32'd50);
        checks++;
        if (snap_a() !== e) begin fails++; $display("FAIL abort_reset: got %h required %h", snap_a(), e); end
        reset_a = 1'b0;
        tick();
        e = mk(1, 16'h1234, 16'h0, 0, 32'd50, 32'd51, 32'd51);
        checks++;
        if (snap_a() !== e) begin fails++; $display("FAIL abort_reset_next: got %h required %h", snap_a(), e); end
    endtask

    task automatic test_wrap();
        mem_b[8'hFF] = 16'h0011; mem_b[8'h00] = 16'h8002; mem_b[8'h01] = 16'h0BEE;
        reset_b = 1'b0; branch_b = 1'b1; ba_b = 8'hFF;
        tick();
        checks++;
        if (addr_b !== 8'hFF || valid_b !== 1'b0) begin
            fails++; $display("FAIL wrap_branch: got addr=%h valid=%b required addr=ff valid=0", addr_b, valid_b);
        end
        branch_b = 1'b0;
        tick();
        checks++;
        if (valid_b !== 1'b1 || inst_b !== 16'h0011 || pc_b !== 8'hFF || pcn_b !== 8'h00 || addr_b !== 8'h00) begin
            fails++;
            $display("FAIL wrap_single: got v=%b inst=%h pc=%h pcn=%h addr=%h required v=1 inst=0011 pc=ff pcn=00 addr=00",
                     valid_b, inst_b, pc_b, pcn_b, addr_b);
        end
        tick();
        tick();
        checks++;
        if (valid_b !== 1'b1 || inst_b !== 16'h8002 || imm_b !== 16'h0BEE || has_b !== 1'b1 ||
            pc_b !== 8'h00 || pcn_b !== 8'h02) begin
            fails++;
            $display("FAIL wrap_two_word: got v=%b inst=%h imm=%h has=%b pc=%h pcn=%h required v=1 inst=8002 imm=0bee has=1 pc=00 pcn=02",
                     valid_b, inst_b, imm_b, has_b, pc_b, pcn_b);
        end
    endtask

    // Instruction-level model: tracks where the current instruction starts and
    // whether its first word has already been consumed; completed instructions
    // are re-read from memory by address.
    task automatic test_random();
        snap_t       e;
        logic [31:0] m_pc, m_start;
        logic        m_mid;
        logic [15:0] w;
        logic        r, b, s;
        logic [15:0] ba;
        for (int i = 0; i < 256; i++) mem_a[i] = 16'($urandom);
        reset_a = 1'b1; branch_a = 1'b0; stall_a = 1'b0;
        tick();
        m_pc = 32'd50; m_start = '0; m_mid = 1'b0;
        e = mk(0, 16'h0, 16'h0, 0, 32'd0, 32'd0, 32'd50);
        for (int n = 0; n < 400; n++) begin
            r  = ($urandom_range(0, 49) == 0);
            b  = ($urandom_range(0, 9) == 0);
            s  = ($urandom_range(0, 4) == 0);
            ba = 16'($urandom);
            reset_a = r; branch_a = b; stall_a = s; ba_a = ba;
            tick();
            if (r) begin
                m_pc = 32'd50; m_mid = 1'b0;
                e = mk(0, 16'h0, 16'h0, 0, 32'd0, 32'd0, 32'd50);
            end else if (b) begin
                m_pc = {{16{ba[15]}}, ba}; m_mid = 1'b0; e.valid = 1'b0;
            end else if (!s) begin
                w = mem_a[m_pc[7:0]];
                if (m_mid) begin
                    e.valid = 1'b1; e.inst = mem_a[m_start[7:0]]; e.imm = w; e.has = 1'b1;
                    e.pc = m_start; e.pcn = m_start + 32'd2; m_mid = 1'b0;
                end else if (w[15]) begin
                    m_start = m_pc; m_mid = 1'b1; e.valid = 1'b0;
                end else begin
                    e.valid = 1'b1; e.inst = w; e.imm = '0; e.has = 1'b0;
                    e.pc = m_pc; e.pcn = m_pc + 32'd1;
                end
                m_pc = m_pc + 32'd1;
            end
            e.addr = m_pc;
            checks++;
            if (snap_a() !== e) begin fails++; $display("FAIL rand[%0d]: got %h required %h", n, snap_a(), e); end
        end
        reset_a = 1'b0; branch_a = 1'b0; stall_a = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_a = 1'b1; stall_a = 1'b0; branch_a = 1'b0; ba_a = '0;
        reset_b = 1'b1; stall_b = 1'b0; branch_b = 1'b0; ba_b = '0;
        for (int i = 0; i < 256; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
        test_reset();
        test_single_word();
        test_two_word();
        test_stall();
        test_branch_sext();
        test_abort();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
